// File: rtl/pe_conv_row_acc_if.sv
// ---------------------------------------------------------------------------
// pe_conv_row_acc_if
//   Bundles the two streaming channels of the row-accumulating conv PE.
//
//   Input channel (feeder -> PE):
//     in_valid, in_ready, in_row[N*DW], filter[K*DW], sat_en
//   Output channel (PE -> writeback):
//     out_valid, out_ready, out_data[L*ACC_W], out_sat
//
//   Modports:
//     master : the side that feeds rows and consumes results (feeder/writeback)
//     slave  : the PE itself
// ---------------------------------------------------------------------------
interface pe_conv_row_acc_if #(
  parameter int DW    = 2,
  parameter int N     = 8,
  parameter int K     = 3,
  parameter int ACC_W = 8
);
  localparam int L = N - K + 1;

  logic               in_valid;
  logic               in_ready;
  logic [N*DW-1:0]    in_row;
  logic [K*DW-1:0]    filter;
  logic               sat_en;
  logic               out_valid;
  logic               out_ready;
  logic [L*ACC_W-1:0] out_data;
  logic               out_sat;

  modport master (
    output in_valid, in_row, filter, sat_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_row, filter, sat_en, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/pe_conv_row_acc.sv
// ---------------------------------------------------------------------------
// pe_conv_row_acc
//   Accumulates the 1-D convolution of ROWS consecutive input rows into one
//   2-D convolution output row of L = N-K+1 lanes. Each lane is ACC_W bits
//   and either saturates or wraps on overflow, chosen per accepted row.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     clr   : synchronous frame abort (drops partial frame or pending output)
//     bus   : slave side of pe_conv_row_acc_if (row input + result output)
//
//   Two states: ACC takes rows, OUT presents the finished frame until the
//   downstream handshake (or a clr) returns to ACC.
// ---------------------------------------------------------------------------
module pe_conv_row_acc #(
  parameter int DW    = 2,
  parameter int N     = 8,
  parameter int K     = 3,
  parameter int ROWS  = 3,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  pe_conv_row_acc_if.slave bus
);
  localparam int L     = N - K + 1;
  // Full-precision row sum: K products of two DW-bit values.
  localparam int RS_W  = 2 * DW + $clog2(K);
  // One bit wider than the wider operand so the overflow test is exact.
  localparam int SUM_W = ((ACC_W > RS_W) ? ACC_W : RS_W) + 1;
  localparam int CNT_W = $clog2(ROWS + 1);

  localparam logic [SUM_W-1:0] ACC_MAX  = SUM_W'((1 << ACC_W) - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

  typedef enum logic {
    ST_ACC,
    ST_OUT
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] row_cnt_q;
  logic             out_sat_q;
  logic [ACC_W-1:0] acc_q [L];
  logic [ACC_W-1:0] acc_d [L];
  logic [L-1:0]     lane_ovf;

  // -------------------------------------------------------------------------
  // Per-lane datapath: row sum, accumulate, overflow handling.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    logic [RS_W-1:0]  rs;
    logic [SUM_W-1:0] sum;
    logic             ovf;
    logic [ACC_W-1:0] nxt;

    always_comb begin
      logic [RS_W-1:0] a;
      logic [RS_W-1:0] b;
      rs = '0;
      a  = '0;
      b  = '0;
      for (int t = 0; t < K; t++) begin
        // Widen both operands first so the product keeps its full width.
        a  = RS_W'(bus.in_row[(gi + t) * DW +: DW]);
        b  = RS_W'(bus.filter[t * DW +: DW]);
        rs = rs + a * b;
      end
      sum = SUM_W'(acc_q[gi]) + SUM_W'(rs);
      ovf = (sum > ACC_MAX);
      nxt = sum[ACC_W-1:0];
      if (ovf && bus.sat_en) begin
        nxt = ACC_MAX[ACC_W-1:0];
      end
    end

    assign acc_d[gi]    = nxt;
    assign lane_ovf[gi] = ovf;
    assign bus.out_data[gi * ACC_W +: ACC_W] = acc_q[gi];
  end

  // -------------------------------------------------------------------------
  // Control + state
  // -------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_sat   = out_sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      row_cnt_q <= '0;
      out_sat_q <= 1'b0;
      acc_q     <= '{default: '0};
    end else if (clr) begin
      // Abort wins over both handshakes; a concurrent row or out_ready is ignored.
      state_q   <= ST_ACC;
      row_cnt_q <= '0;
      out_sat_q <= 1'b0;
      acc_q     <= '{default: '0};
    end else begin
      case (state_q)
        ST_ACC: begin
          if (bus.in_valid) begin
            acc_q     <= acc_d;
            out_sat_q <= out_sat_q | (|lane_ovf);
            if (row_cnt_q == CNT_LAST) begin
              row_cnt_q <= '0;
              state_q   <= ST_OUT;
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        ST_OUT: begin
          // Result is held stable until the downstream takes it.
          if (bus.out_ready) begin
            acc_q     <= '{default: '0};
            out_sat_q <= 1'b0;
            state_q   <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end
endmodule
